// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a qualified lock and only then releases sys_rst_n.
// Optional lol_count output is enabled with `define PLL_SUP_LOL_COUNT_EN.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_cnt
`ifdef PLL_SUP_LOL_COUNT_EN
    ,
    output logic [7:0] lol_count
`endif
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     lock_s;
    logic [3:0]               retry_inc;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign retry_inc = retry_cnt + 4'd1;

    // pll_lock comes from the PLL analog domain, so it is only ever used after this chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else if (force_relock) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            if (state == FAULT) begin
                retry_cnt <= 4'd0;
            end
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        retry_cnt <= retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= RESET_PLL;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // A dropout here restarts the lock wait without charging a retry.
                STABILIZE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        locked    <= 1'b1;
                        retry_cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        state     <= RESET_PLL;
                        pll_reset <= 1'b1;
                        sys_rst_n <= 1'b0;
                        locked    <= 1'b0;
                    end
                end
                FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    state     <= RESET_PLL;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    sys_rst_n <= 1'b0;
                    locked    <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SUP_LOL_COUNT_EN
    // Counts genuine lock losses in RUN only; a requested relock is not a loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lol_count <= 8'd0;
        end else if (state == RUN && !force_relock && !lock_s && lol_count != 8'hFF) begin
            lol_count <= lol_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed bring-up scenarios followed by random lock activity,
// every cycle compared against a timestamp-based behavioural model.
module tb_pll_lock_supervisor;

    localparam int PLL_RST_CYCLES      = 4;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES         = 3;
    localparam int SYNC_STAGES         = 2;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;
`ifdef PLL_SUP_LOL_COUNT_EN
    logic [7:0] lol_count;
`endif

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES),
        .SYNC_STAGES        (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .force_relock(force_relock),
        .pll_reset   (pll_reset),
        .sys_rst_n   (sys_rst_n),
        .locked      (locked),
        .fault       (fault),
        .retry_cnt   (retry_cnt)
`ifdef PLL_SUP_LOL_COUNT_EN
        ,
        .lol_count   (lol_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model: phase plus the edge index at which it was entered; elapsed time is plain subtraction.
    typedef enum {M_PULSE, M_ACQUIRE, M_QUALIFY, M_RUNNING, M_FAULTED} mphase_t;
    mphase_t m_phase;
    int      edge_idx  = 0;
    int      enter_idx = 0;
    int      m_retries = 0;
    int      m_lol     = 0;
    bit      hist[$];

    function automatic void model_reset();
        m_phase   = M_PULSE;
        enter_idx = edge_idx;
        m_retries = 0;
        m_lol     = 0;
        hist.delete();
        for (int k = 0; k < SYNC_STAGES; k++) hist.push_back(1'b0);
    endfunction

    function automatic void enter(input mphase_t p);
        m_phase   = p;
        enter_idx = edge_idx;
    endfunction

    function automatic void model_edge(input bit pin, input bit relock);
        bit ls;
        int age;
        ls = hist.pop_front();
        hist.push_back(pin);
        edge_idx++;
        age = edge_idx - enter_idx;
        if (relock) begin
            if (m_phase == M_FAULTED) m_retries = 0;
            enter(M_PULSE);
        end else begin
            case (m_phase)
                M_PULSE:   if (age == PLL_RST_CYCLES) enter(M_ACQUIRE);
                M_ACQUIRE: begin
                    if (ls) enter(M_QUALIFY);
                    else if (age == LOCK_TIMEOUT_CYCLES) begin
                        m_retries++;
                        enter((m_retries == MAX_RETRIES) ? M_FAULTED : M_PULSE);
                    end
                end
                M_QUALIFY: begin
                    if (!ls) enter(M_ACQUIRE);
                    else if (age == LOCK_STABLE_CYCLES) begin
                        m_retries = 0;
                        enter(M_RUNNING);
                    end
                end
                M_RUNNING: begin
                    if (!ls) begin
                        if (m_lol < 255) m_lol++;
                        enter(M_PULSE);
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        cmp("pll_reset", {31'd0, pll_reset}, (m_phase == M_PULSE || m_phase == M_FAULTED) ? 32'd1 : 32'd0);
        cmp("sys_rst_n", {31'd0, sys_rst_n}, (m_phase == M_RUNNING) ? 32'd1 : 32'd0);
        cmp("locked",    {31'd0, locked},    (m_phase == M_RUNNING) ? 32'd1 : 32'd0);
        cmp("fault",     {31'd0, fault},     (m_phase == M_FAULTED) ? 32'd1 : 32'd0);
        cmp("retry_cnt", {28'd0, retry_cnt}, 32'(m_retries));
`ifdef PLL_SUP_LOL_COUNT_EN
        cmp("lol_count", {24'd0, lol_count}, 32'(m_lol));
`endif
    endtask

    task automatic applyStimulus(input bit lock, input bit relock);
        pll_lock     = lock;
        force_relock = relock;
        @(posedge clk);
        model_edge(lock, relock);
        #1;
        checkOutput();
        force_relock = 1'b0;
    endtask

    initial begin
        int n;
        bit done;
        int lol_before;
        bit lvl;
        int len;

        rst_n        = 1'b0;
        pll_lock     = 1'b0;
        force_relock = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("reset_pll_reset", {31'd0, pll_reset}, 32'd1);
        cmp("reset_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        cmp("reset_fault",     {31'd0, fault},     32'd0);
        checkOutput();
        rst_n = 1'b1;
        model_reset();

        // Clean bring-up: reset pulse length, then release latency from the pin rising.
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus(1'b0, 1'b0);
            n++;
            if (pll_reset === 1'b0) done = 1;
        end
        cmp("bringup_pulse_len", 32'(n), 32'd4);
        repeat (9) applyStimulus(1'b0, 1'b0);
        n = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            applyStimulus(1'b1, 1'b0);
            n++;
            if (sys_rst_n === 1'b1) done = 1;
        end
        cmp("bringup_latency", 32'(n), 32'd11);
        cmp("bringup_locked", {31'd0, locked}, 32'd1);
        cmp("bringup_retry", {28'd0, retry_cnt}, 32'd0);

        // Loss of lock in RUN, then the pin stays low long enough to exhaust retries.
        repeat (5) applyStimulus(1'b1, 1'b0);
        n = 0; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            applyStimulus(1'b0, 1'b0);
            n++;
            if (sys_rst_n === 1'b0) done = 1;
        end
        cmp("lol_latency", 32'(n), 32'd3);
        cmp("lol_pll_reset", {31'd0, pll_reset}, 32'd1);
`ifdef PLL_SUP_LOL_COUNT_EN
        cmp("lol_count_after_loss", {24'd0, lol_count}, 32'd1);
`endif
        repeat (130) applyStimulus(1'b0, 1'b0);
        cmp("timeout_fault", {31'd0, fault}, 32'd1);
        cmp("timeout_retry", {28'd0, retry_cnt}, 32'd3);
        applyStimulus(1'b0, 1'b1);
        cmp("relock_fault", {31'd0, fault}, 32'd0);
        cmp("relock_retry", {28'd0, retry_cnt}, 32'd0);
        cmp("relock_pll_reset", {31'd0, pll_reset}, 32'd1);

        // Lock chatter during qualification.
        repeat (6) applyStimulus(1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b0);
        cmp("chatter_released", {31'd0, sys_rst_n}, 32'd1);
        cmp("chatter_retry", {28'd0, retry_cnt}, 32'd0);

        // force_relock on the very edge the synchronised lock drops.
        lol_before = m_lol;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        cmp("relock_lol_model", 32'(m_lol), 32'(lol_before));
        cmp("relock_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        repeat (8) applyStimulus(1'b1, 1'b0);

        // Asynchronous reset in the middle of qualification.
        #3;
        rst_n = 1'b0;
        #1;
        cmp("async_pll_reset", {31'd0, pll_reset}, 32'd1);
        cmp("async_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        cmp("async_locked",    {31'd0, locked},    32'd0);
        model_reset();
        checkOutput();
        #1;
        rst_n = 1'b1;

        // Random lock activity with occasional relock requests.
        for (int seg = 0; seg < 60; seg++) begin
            lvl = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 45);
            for (int c = 0; c < len; c++) begin
                applyStimulus(lvl, $urandom_range(0, 39) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumes the PLL's LOCK status and drives its RESET input. Sequences PLL bring-up: reset pulse, lock wait with timeout and retry, stability qualification. Only then releases a system reset to the SDRAM controller and user logic. Runs on the PLL reference clock (board 50 MHz), so it keeps working while PLL outputs are absent.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_reset is held high per attempt (min 1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before an attempt is declared failed (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive cycles lock must stay high before release
MAX_RETRIES, 7, failed attempts (1..15) before entering FAULT
SYNC_STAGES, 2, flip-flop stages on pll_lock (min 2)

Ports:
clk  input  1  reference clock, same net as PLL CLKIN
rst_n  input  1  asynchronous active-low reset
pll_lock  input  1  PLL LOCK, asynchronous to clk
force_relock  input  1  single-cycle request to re-run acquisition
pll_reset  output  1  to PLL RESET, active high
sys_rst_n  output  1  downstream reset, active low, deasserts synchronously to clk
locked  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_cnt  output  4  failed attempts in the current acquisition

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low; assertion forces reset state immediately. Deassertion is assumed synchronised upstream.
- All outputs are registered. Reset values: pll_reset=1, sys_rst_n=0, locked=0, fault=0, retry_cnt=0, state=RESET_PLL, counter=0.
- pll_lock passes through a SYNC_STAGES synchroniser, giving lock_s. Only lock_s is used.
- Single down-counter/up-counter cnt, width $clog2(max of the three cycle parameters)+1. Cleared on every state transition.
- RESET_PLL: pll_reset=1, sys_rst_n=0. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1: go to STABILIZE.
  - cnt reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: retry_cnt+1. If the new value equals MAX_RETRIES go to FAULT, else go to RESET_PLL.
  - If lock_s rises on the timeout cycle, lock wins.
- STABILIZE:
  - lock_s=0 on any cycle: back to WAIT_LOCK with cnt cleared. This is a fresh timeout and does not increment retry_cnt.
  - LOCK_STABLE_CYCLES consecutive high cycles: go to RUN; sys_rst_n=1 and locked=1 from the next edge; retry_cnt cleared.
- RUN:
  - lock_s=0: go to RESET_PLL; sys_rst_n=0 and locked=0 on the same edge.
  - Worst-case latency from the pll_lock pin falling to sys_rst_n low is SYNC_STAGES+1 cycles.
- FAULT: pll_reset=1, sys_rst_n=0, fault=1. Exits only on rst_n, or on force_relock (clears retry_cnt and fault, goes to RESET_PLL).
- force_relock:
  - In RUN, STABILIZE or WAIT_LOCK: go to RESET_PLL next edge. retry_cnt unchanged, except cleared from FAULT.
  - In RESET_PLL: restarts the reset pulse (cnt cleared).
  - Takes priority over lock or timeout events on the same cycle.
- sys_rst_n never deasserts unless the FSM passes through STABILIZE to RUN. No glitches, because it is a register output.

Optional Feature:
Macro PLL_SUP_LOL_COUNT_EN.
- Defined: adds output lol_count, 8 bits, reset 0. It increments on each RUN->RESET_PLL transition caused by lock_s=0 (not by force_relock) and saturates at 255. It is not cleared by force_relock.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2.
- Clean bring-up: pll_lock rises 10 cycles after pll_reset falls -> sys_rst_n=1 and locked=1 exactly 2+8 (+1 register) cycles after the rise; pll_reset high for exactly 4 cycles after rst_n; retry_cnt=0.
- Timeout retries: pll_lock held 0 -> three 4-cycle pll_reset pulses, each separated by 32 cycles; then fault=1, retry_cnt=3, pll_reset stays 1 for the rest of sim; force_relock -> fault=0, retry_cnt=0, new pulse.
- Lock chatter: pll_lock high 5 cycles, low 1, high 20 in STABILIZE -> no release until 8 consecutive synced highs; retry_cnt remains 0.
- Loss of lock in RUN: drop pll_lock -> sys_rst_n=0 within 3 cycles; a new 4-cycle pll_reset follows; with PLL_SUP_LOL_COUNT_EN, lol_count goes 0->1.
- force_relock in RUN on the same cycle that lock_s falls -> single RESET_PLL entry; lol_count unchanged.
- rst_n asserted mid-STABILIZE -> all outputs take reset values asynchronously, before the next clk edge.
